// File: rtl/rt_sched_pkg.sv
// Shared types and default constants for the raytracer job scheduler.
// Job descriptors, core results and the scheduler FSM state live here.
package rt_sched_pkg;

  localparam int DEF_FIFO_DEPTH  = 4;
  localparam int DEF_TAG_W       = 4;
  localparam int DEF_WDOG_CYCLES = 4096;

  typedef struct packed {
    logic [5:0]  ix0;
    logic [5:0]  iy0;
    logic [5:0]  iz0;
    logic        sx;
    logic        sy;
    logic        sz;
    logic [31:0] next_x;
    logic [31:0] next_y;
    logic [31:0] next_z;
    logic [31:0] inc_x;
    logic [31:0] inc_y;
    logic [31:0] inc_z;
    logic [9:0]  max_steps;
  } job_t;

  typedef struct packed {
    logic        hit;
    logic        timeout;
    logic [2:0]  face;
    logic [15:0] steps;
    logic [15:0] vx;
    logic [15:0] vy;
    logic [15:0] vz;
  } core_res_t;

  typedef struct packed {
    core_res_t res;
    logic      wdog;
  } res_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_RUN   = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  // Statistics counters stick at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    logic [15:0] r;
    if (v == 16'hFFFF) begin
      r = v;
    end else begin
      r = v + 16'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rt_sync_fifo.sv
// Single-clock FIFO with registered count, full and empty flags.
// DEPTH must be a power of two so the pointers wrap naturally.
module rt_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;

  // Next pointers, occupancy and flags.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CNT_W'(DEPTH));
    empty_d = (count_d == CNT_W'(0));
  end

  // Control state.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage needs no reset; occupancy decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/ray_job_sched.sv
// Raytracer job scheduler: queues host jobs, arbitrates against scene loads,
// runs one job at a time on the core with a watchdog and returns results in order.
module ray_job_sched
  import rt_sched_pkg::*;
#(
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int TAG_W       = DEF_TAG_W,
  parameter int WDOG_CYCLES = DEF_WDOG_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_job_valid,
  output logic             s_job_ready,
  input  logic [TAG_W-1:0] s_job_tag,
  input  job_t             s_job,
  output logic             core_job_valid,
  input  logic             core_job_ready,
  output job_t             core_job,
  input  logic             core_ray_done,
  input  core_res_t        core_res,
  input  logic             load_req,
  output logic             load_gnt,
  output logic             m_res_valid,
  input  logic             m_res_ready,
  output logic [TAG_W-1:0] m_res_tag,
  output res_t             m_res,
  output logic [15:0]      stat_jobs,
  output logic [15:0]      stat_hits,
  output logic             stat_wdog_err,
  output logic             busy
);

  localparam int FW   = TAG_W + $bits(job_t);
  localparam int WD_W = $clog2(WDOG_CYCLES);

  state_e           state_q, state_d;
  logic             last_load_q, last_load_d;
  logic [TAG_W-1:0] run_tag_q, run_tag_d;
  logic [WD_W-1:0]  wdog_cnt_q, wdog_cnt_d;
  logic             core_job_valid_q, core_job_valid_d;
  logic             load_gnt_q, load_gnt_d;
  logic             m_res_valid_q, m_res_valid_d;
  logic [TAG_W-1:0] m_res_tag_q, m_res_tag_d;
  res_t             m_res_q, m_res_d;
  logic [15:0]      stat_jobs_q, stat_jobs_d;
  logic [15:0]      stat_hits_q, stat_hits_d;
  logic             stat_wdog_err_q, stat_wdog_err_d;

  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [FW-1:0]    fifo_dout;
  logic [TAG_W-1:0] head_tag;
  job_t             head_job;

  assign fifo_push = s_job_valid && !fifo_full;
  assign fifo_pop  = core_job_valid_q && core_job_ready;

  rt_sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   ({s_job_tag, s_job}),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign {head_tag, head_job} = fifo_dout;

  // Scheduler next-state; last_load records which side won the previous grant.
  always_comb begin
    state_d         = state_q;
    last_load_d     = last_load_q;
    run_tag_d       = run_tag_q;
    wdog_cnt_d      = wdog_cnt_q;
    m_res_d         = m_res_q;
    m_res_tag_d     = m_res_tag_q;
    stat_jobs_d     = stat_jobs_q;
    stat_hits_d     = stat_hits_q;
    stat_wdog_err_d = stat_wdog_err_q;
    case (state_q)
      ST_IDLE: begin
        if (load_req && (fifo_empty || !last_load_q)) begin
          state_d     = ST_LOAD;
          last_load_d = 1'b1;
        end else if (!fifo_empty) begin
          state_d     = ST_ISSUE;
          last_load_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (!load_req) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_ISSUE: begin
        if (core_job_ready) begin
          run_tag_d  = head_tag;
          wdog_cnt_d = '0;
          state_d    = ST_RUN;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_RUN: begin
        // A completion on the terminal watchdog cycle still counts as a real result.
        if (core_ray_done) begin
          m_res_d.res  = core_res;
          m_res_d.wdog = 1'b0;
          m_res_tag_d  = run_tag_q;
          state_d      = ST_RESP;
        end else if (wdog_cnt_q == WD_W'(WDOG_CYCLES - 1)) begin
          m_res_d         = '0;
          m_res_d.wdog    = 1'b1;
          m_res_tag_d     = run_tag_q;
          stat_wdog_err_d = 1'b1;
          state_d         = ST_RESP;
        end else begin
          wdog_cnt_d = wdog_cnt_q + WD_W'(1);
        end
      end
      ST_RESP: begin
        if (m_res_ready) begin
          stat_jobs_d = sat_inc16(stat_jobs_q);
          if (m_res_q.res.hit) begin
            stat_hits_d = sat_inc16(stat_hits_q);
          end else begin
            stat_hits_d = stat_hits_q;
          end
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    core_job_valid_d = (state_d == ST_ISSUE);
    load_gnt_d       = (state_d == ST_LOAD);
    m_res_valid_d    = (state_d == ST_RESP);
  end

  // Scheduler state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      last_load_q      <= 1'b1;
      run_tag_q        <= '0;
      wdog_cnt_q       <= '0;
      core_job_valid_q <= 1'b0;
      load_gnt_q       <= 1'b0;
      m_res_valid_q    <= 1'b0;
      m_res_tag_q      <= '0;
      m_res_q          <= '0;
      stat_jobs_q      <= 16'd0;
      stat_hits_q      <= 16'd0;
      stat_wdog_err_q  <= 1'b0;
    end else begin
      state_q          <= state_d;
      last_load_q      <= last_load_d;
      run_tag_q        <= run_tag_d;
      wdog_cnt_q       <= wdog_cnt_d;
      core_job_valid_q <= core_job_valid_d;
      load_gnt_q       <= load_gnt_d;
      m_res_valid_q    <= m_res_valid_d;
      m_res_tag_q      <= m_res_tag_d;
      m_res_q          <= m_res_d;
      stat_jobs_q      <= stat_jobs_d;
      stat_hits_q      <= stat_hits_d;
      stat_wdog_err_q  <= stat_wdog_err_d;
    end
  end

  assign s_job_ready    = !fifo_full;
  assign core_job_valid = core_job_valid_q;
  assign core_job       = head_job;
  assign load_gnt       = load_gnt_q;
  assign m_res_valid    = m_res_valid_q;
  assign m_res_tag      = m_res_tag_q;
  assign m_res          = m_res_q;
  assign stat_jobs      = stat_jobs_q;
  assign stat_hits      = stat_hits_q;
  assign stat_wdog_err  = stat_wdog_err_q;
  assign busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ray_job_sched.sv
// Directed bench for ray_job_sched with a queue-based reference model
// checked every cycle, plus hand-computed expectations per scenario.
module tb_ray_job_sched;
  import rt_sched_pkg::*;

  localparam int FIFO_DEPTH  = 4;
  localparam int TAG_W       = 4;
  localparam int WDOG_CYCLES = 4096;

  logic             clk, rst;
  logic             s_job_valid, s_job_ready;
  logic [TAG_W-1:0] s_job_tag;
  job_t             s_job;
  logic             core_job_valid, core_job_ready;
  job_t             core_job;
  logic             core_ray_done;
  core_res_t        core_res;
  logic             load_req, load_gnt;
  logic             m_res_valid, m_res_ready;
  logic [TAG_W-1:0] m_res_tag;
  res_t             m_res;
  logic [15:0]      stat_jobs, stat_hits;
  logic             stat_wdog_err, busy;

  ray_job_sched #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .TAG_W      (TAG_W),
    .WDOG_CYCLES(WDOG_CYCLES)
  ) dut (
    .clk(clk), .rst(rst),
    .s_job_valid(s_job_valid), .s_job_ready(s_job_ready),
    .s_job_tag(s_job_tag), .s_job(s_job),
    .core_job_valid(core_job_valid), .core_job_ready(core_job_ready), .core_job(core_job),
    .core_ray_done(core_ray_done), .core_res(core_res),
    .load_req(load_req), .load_gnt(load_gnt),
    .m_res_valid(m_res_valid), .m_res_ready(m_res_ready),
    .m_res_tag(m_res_tag), .m_res(m_res),
    .stat_jobs(stat_jobs), .stat_hits(stat_hits),
    .stat_wdog_err(stat_wdog_err), .busy(busy)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  typedef struct {
    logic [TAG_W-1:0] tag;
    job_t             job;
  } entry_t;

  // Reference model: queued jobs, the job on the core, and the pending result.
  entry_t           mq[$];
  bit               running, exp_vld, model_rdy;
  int               run_cycles;
  logic [TAG_W-1:0] inflight_tag, exp_tag;
  res_t             exp_res;
  logic [15:0]      m_jobs, m_hits;
  logic             m_werr;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench did not finish");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic job_t mk_job(input int n);
    job_t j;
    j.ix0       = 6'(n);
    j.iy0       = 6'(n + 1);
    j.iz0       = 6'(n + 2);
    j.sx        = n[0];
    j.sy        = n[1];
    j.sz        = n[2];
    j.next_x    = 32'(n) * 32'd3 + 32'h0000_0100;
    j.next_y    = 32'(n) * 32'd5 + 32'h0000_0200;
    j.next_z    = 32'(n) * 32'd7 + 32'h0000_0300;
    j.inc_x     = 32'hA000_0000 + 32'(n);
    j.inc_y     = 32'hB000_0000 + 32'(n);
    j.inc_z     = 32'hC000_0000 + 32'(n);
    j.max_steps = 10'(n + 50);
    return j;
  endfunction

  function automatic core_res_t mk_res(input logic hit, input logic [15:0] steps);
    core_res_t r;
    r.hit     = hit;
    r.timeout = 1'b0;
    r.face    = steps[2:0];
    r.steps   = steps;
    r.vx      = steps + 16'd1;
    r.vy      = steps + 16'd2;
    r.vz      = steps + 16'd3;
    return r;
  endfunction

  // Model update from the handshakes seen just before each edge.
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        mq.delete();
        running    = 1'b0;
        exp_vld    = 1'b0;
        exp_res    = '0;
        exp_tag    = '0;
        m_jobs     = 16'd0;
        m_hits     = 16'd0;
        m_werr     = 1'b0;
        run_cycles = 0;
      end else begin
        model_rdy = (mq.size() < FIFO_DEPTH);
        if (exp_vld && m_res_ready) begin
          exp_vld = 1'b0;
          if (m_jobs != 16'hFFFF) m_jobs = m_jobs + 16'd1;
          if (exp_res.res.hit && m_hits != 16'hFFFF) m_hits = m_hits + 16'd1;
        end
        if (running) begin
          if (core_ray_done) begin
            exp_res.res  = core_res;
            exp_res.wdog = 1'b0;
            exp_tag      = inflight_tag;
            exp_vld      = 1'b1;
            running      = 1'b0;
          end else if (run_cycles == WDOG_CYCLES - 1) begin
            exp_res      = '0;
            exp_res.wdog = 1'b1;
            exp_tag      = inflight_tag;
            exp_vld      = 1'b1;
            running      = 1'b0;
            m_werr       = 1'b1;
          end else begin
            run_cycles++;
          end
        end
        if (core_job_valid && core_job_ready && mq.size() > 0) begin
          inflight_tag = mq[0].tag;
          void'(mq.pop_front());
          running    = 1'b1;
          run_cycles = 0;
        end
        if (s_job_valid && model_rdy) mq.push_back('{tag: s_job_tag, job: s_job});
      end
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("s_job_ready", 256'(s_job_ready), 256'(mq.size() < FIFO_DEPTH));
        chk("m_res_valid", 256'(m_res_valid), 256'(exp_vld));
        if (exp_vld) begin
          chk("m_res_tag", 256'(m_res_tag), 256'(exp_tag));
          chk("m_res", 256'(m_res), 256'(exp_res));
        end
        chk("stat_jobs", 256'(stat_jobs), 256'(m_jobs));
        chk("stat_hits", 256'(stat_hits), 256'(m_hits));
        chk("stat_wdog_err", 256'(stat_wdog_err), 256'(m_werr));
        if (core_job_valid) begin
          chk("issue_nonempty", 256'(mq.size() != 0), 256'(1));
          if (mq.size() != 0) chk("core_job", 256'(core_job), 256'(mq[0].job));
          chk("one_in_flight", 256'(running || exp_vld), 256'(0));
          chk("no_issue_in_load", 256'(load_gnt), 256'(0));
        end
        if (running || exp_vld) chk("busy_active", 256'(busy), 256'(1));
        if (mq.size() == 0 && !running && !exp_vld && !load_gnt)
          chk("busy_idle", 256'(busy), 256'(0));
      end
    end
  end

  task automatic push_job(input logic [TAG_W-1:0] tag, input int n);
    bit acc;
    bit pushed;
    pushed      = 1'b0;
    s_job_tag   = tag;
    s_job       = mk_job(n);
    s_job_valid = 1'b1;
    for (int k = 0; k < 300; k++) begin
      acc = s_job_ready;
      tick();
      if (acc) begin
        pushed = 1'b1;
        break;
      end
    end
    s_job_valid = 1'b0;
    chk("push_accept", 256'(pushed), 256'(1));
  endtask

  task automatic wait_issue();
    for (int k = 0; k < 200; k++) begin
      if (core_job_valid) break;
      tick();
    end
    chk("wait_issue", 256'(core_job_valid), 256'(1));
  endtask

  task automatic serve_one(input logic hit, input logic [15:0] steps, output logic [TAG_W-1:0] tag_o);
    core_job_ready = 1'b1;
    wait_issue();
    tick();
    core_job_ready = 1'b0;
    tick();
    core_res      = mk_res(hit, steps);
    core_ray_done = 1'b1;
    tick();
    core_ray_done = 1'b0;
    core_res      = '0;
    m_res_ready   = 1'b1;
    for (int k = 0; k < 50; k++) begin
      if (m_res_valid) break;
      tick();
    end
    chk("wait_result", 256'(m_res_valid), 256'(1));
    tag_o = m_res_tag;
    tick();
    m_res_ready = 1'b0;
  endtask

  task automatic check_reset_state(input string pfx);
    chk({pfx, "_s_job_ready"}, 256'(s_job_ready), 256'(1));
    chk({pfx, "_core_job_valid"}, 256'(core_job_valid), 256'(0));
    chk({pfx, "_load_gnt"}, 256'(load_gnt), 256'(0));
    chk({pfx, "_m_res_valid"}, 256'(m_res_valid), 256'(0));
    chk({pfx, "_m_res"}, 256'(m_res), 256'(0));
    chk({pfx, "_m_res_tag"}, 256'(m_res_tag), 256'(0));
    chk({pfx, "_stat_jobs"}, 256'(stat_jobs), 256'(0));
    chk({pfx, "_stat_hits"}, 256'(stat_hits), 256'(0));
    chk({pfx, "_stat_wdog_err"}, 256'(stat_wdog_err), 256'(0));
    chk({pfx, "_busy"}, 256'(busy), 256'(0));
  endtask

  initial begin
    logic [TAG_W-1:0] t;
    logic [TAG_W-1:0] got [5];
    res_t             wexp;
    int               n;

    rst = 1'b1; s_job_valid = 1'b0; s_job_tag = '0; s_job = '0;
    core_job_ready = 1'b0; core_ray_done = 1'b0; core_res = '0;
    load_req = 1'b0; m_res_ready = 1'b0;
    tick(); tick();
    check_reset_state("rst0");
    rst = 1'b0;
    chk_en = 1'b1;

    // Single job: issue latency, result fields and stats.
    core_job_ready = 1'b1;
    push_job(4'd3, 5);
    chk("t1_not_yet_issued", 256'(core_job_valid), 256'(0));
    tick();
    chk("t1_issue_e1", 256'(core_job_valid), 256'(1));
    chk("t1_ix0", 256'(core_job.ix0), 256'(6'd5));
    tick();
    core_job_ready = 1'b0;
    chk("t1_issued_gone", 256'(core_job_valid), 256'(0));
    chk("t1_busy_run", 256'(busy), 256'(1));
    core_res = mk_res(1'b1, 16'd7);
    core_ray_done = 1'b1;
    tick();
    core_ray_done = 1'b0;
    core_res = '0;
    chk("t1_res_valid", 256'(m_res_valid), 256'(1));
    chk("t1_res_tag", 256'(m_res_tag), 256'(4'd3));
    chk("t1_res_steps", 256'(m_res.res.steps), 256'(16'd7));
    chk("t1_res_hit", 256'(m_res.res.hit), 256'(1));
    m_res_ready = 1'b1;
    tick();
    m_res_ready = 1'b0;
    chk("t1_stat_jobs", 256'(stat_jobs), 256'(16'd1));
    chk("t1_stat_hits", 256'(stat_hits), 256'(16'd1));

    // Fill the FIFO, then drain everything in order.
    for (int i = 0; i < 4; i++) push_job(4'(i), 10 + i);
    chk("t2_full_ready", 256'(s_job_ready), 256'(0));
    fork
      push_job(4'd4, 14);
      begin
        for (int i = 0; i < 5; i++) begin
          serve_one(1'(i % 2), 16'(100 + i), t);
          got[i] = t;
        end
      end
    join
    for (int i = 0; i < 5; i++) chk("t2_order", 256'(got[i]), 256'(i));
    chk("t2_stat_jobs", 256'(stat_jobs), 256'(16'd6));
    chk("t2_stat_hits", 256'(stat_hits), 256'(16'd3));

    // Load/job round-robin from a fresh reset.
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    push_job(4'd7, 30);
    load_req = 1'b1;
    push_job(4'd8, 31);
    chk("t3_first_grant_job", 256'(core_job_valid), 256'(1));
    chk("t3_first_no_load", 256'(load_gnt), 256'(0));
    serve_one(1'b1, 16'd40, t);
    chk("t3_tag7", 256'(t), 256'(4'd7));
    tick();
    chk("t3_load_gnt", 256'(load_gnt), 256'(1));
    chk("t3_load_no_issue", 256'(core_job_valid), 256'(0));
    core_job_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t3_load_held", 256'(load_gnt), 256'(1));
      chk("t3_load_held_no_issue", 256'(core_job_valid), 256'(0));
    end
    load_req = 1'b0;
    tick();
    chk("t3_load_released", 256'(load_gnt), 256'(0));
    serve_one(1'b1, 16'd41, t);
    chk("t3_tag8", 256'(t), 256'(4'd8));

    // Watchdog expiry, then a normal job.
    core_job_ready = 1'b0;
    push_job(4'd9, 20);
    wait_issue();
    core_job_ready = 1'b1;
    tick();
    core_job_ready = 1'b0;
    n = 0;
    while (!m_res_valid && n < 5000) begin
      tick();
      n++;
    end
    wexp = '0;
    wexp.wdog = 1'b1;
    chk("t4_wdog_latency", 256'(n), 256'(4096));
    chk("t4_wdog_res", 256'(m_res), 256'(wexp));
    chk("t4_wdog_tag", 256'(m_res_tag), 256'(4'd9));
    chk("t4_wdog_err", 256'(stat_wdog_err), 256'(1));
    m_res_ready = 1'b1;
    tick();
    m_res_ready = 1'b0;
    push_job(4'd10, 21);
    serve_one(1'b0, 16'd3, t);
    chk("t4_next_tag", 256'(t), 256'(4'd10));
    chk("t4_stat_jobs", 256'(stat_jobs), 256'(16'd4));
    chk("t4_stat_hits", 256'(stat_hits), 256'(16'd2));
    chk("t4_err_sticky", 256'(stat_wdog_err), 256'(1));

    // Reset during RUN with two jobs queued.
    push_job(4'd11, 40);
    push_job(4'd12, 41);
    push_job(4'd13, 42);
    wait_issue();
    core_job_ready = 1'b1;
    tick();
    core_job_ready = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check_reset_state("t5");
    rst = 1'b0;
    core_job_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      core_ray_done = 1'(k % 2);
      tick();
      chk("t5_no_issue", 256'(core_job_valid), 256'(0));
      chk("t5_no_result", 256'(m_res_valid), 256'(0));
    end
    core_ray_done  = 1'b0;
    core_job_ready = 1'b0;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
